// File: rtl/cd_pkg.sv
// Shared definitions for the CD upload writer.
// Holds the area codes, the FIFO entry layout and the drain FSM states.
package cd_pkg;

  localparam logic [2:0] AREA_SPR = 3'd0;
  localparam logic [2:0] AREA_PCM = 3'd1;
  localparam logic [2:0] AREA_Z80 = 3'd4;
  localparam logic [2:0] AREA_FIX = 3'd5;

  typedef struct packed {
    logic [24:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } cd_entry_t;

  localparam int ENTRY_W = $bits(cd_entry_t);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } drain_state_t;

endpackage

// File: rtl/cd_upload_fifo.sv
// Synchronous FIFO for upload write entries.
// A push is accepted while full when a pop happens in the same cycle.
module cd_upload_fifo
  import cd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [ENTRY_W-1:0]       wr_data,
  input  logic                     pop,
  output logic [ENTRY_W-1:0]       rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == CW'(0));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rptr];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= AW'(0);
      rptr  <= AW'(0);
      count <= CW'(0);
    end else begin
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wr_data;
    end
  end

endmodule

// File: rtl/cd_upload_writer.sv
// Maps CD upload write strobes to flat memory byte addresses, queues them,
// and drains them to the memory controller over a req/ack handshake.
module cd_upload_writer
  import cd_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [24:0] SPR_BASE   = 25'h0000000,
  parameter logic [24:0] PCM_BASE   = 25'h0400000,
  parameter logic [24:0] Z80_BASE   = 25'h0500000,
  parameter logic [24:0] FIX_BASE   = 25'h0510000
) (
  input  logic        CLK_68KCLK,
  input  logic        RESET,
  input  logic        CD_TR_WR_SPR,
  input  logic        CD_TR_WR_PCM,
  input  logic        CD_TR_WR_Z80,
  input  logic        CD_TR_WR_FIX,
  input  logic [19:1] CD_TR_WR_ADDR,
  input  logic [15:0] CD_TR_WR_DATA,
  input  logic [1:0]  CD_BANK_SPR,
  input  logic        CD_BANK_PCM,
  output logic        MEM_REQ,
  input  logic        MEM_ACK,
  output logic [24:0] MEM_ADDR,
  output logic [15:0] MEM_DATA,
  output logic [1:0]  MEM_BE,
  output logic        BUSY,
  output logic        OVERFLOW,
  output logic        COLLISION
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]         area;
  logic               push;
  logic [2:0]         n_strobes;
  logic               byte_wr;
  cd_entry_t          wr_entry;
  cd_entry_t          head;
  logic [ENTRY_W-1:0] head_raw;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic               pop;
  logic               push_acc;
  logic [CW-1:0]      count_next;

  drain_state_t state;
  drain_state_t state_next;
  logic         req_next;
  logic [24:0]  addr_next;
  logic [15:0]  data_next;
  logic [1:0]   be_next;
  logic         busy_next;

  assign push      = CD_TR_WR_SPR | CD_TR_WR_PCM | CD_TR_WR_Z80 | CD_TR_WR_FIX;
  assign n_strobes = {2'b00, CD_TR_WR_SPR} + {2'b00, CD_TR_WR_PCM}
                   + {2'b00, CD_TR_WR_Z80} + {2'b00, CD_TR_WR_FIX};

  // Strobe priority: SPR > PCM > Z80 > FIX.
  always_comb begin
    area = AREA_FIX;
    if (CD_TR_WR_SPR) begin
      area = AREA_SPR;
    end else if (CD_TR_WR_PCM) begin
      area = AREA_PCM;
    end else if (CD_TR_WR_Z80) begin
      area = AREA_Z80;
    end else begin
      area = AREA_FIX;
    end
  end

  // Address, lane and data mapping for the selected area.
  always_comb begin
    wr_entry.addr = 25'd0;
    wr_entry.data = CD_TR_WR_DATA;
    wr_entry.be   = 2'b11;
    byte_wr       = 1'b0;
    case (area)
      AREA_SPR: wr_entry.addr = SPR_BASE + {3'b000, CD_BANK_SPR, CD_TR_WR_ADDR, 1'b0};
      AREA_PCM: begin
        wr_entry.addr = PCM_BASE + {5'd0, CD_BANK_PCM, CD_TR_WR_ADDR};
        byte_wr       = 1'b1;
      end
      AREA_Z80: begin
        wr_entry.addr = Z80_BASE + {9'd0, CD_TR_WR_ADDR[16:1]};
        byte_wr       = 1'b1;
      end
      AREA_FIX: begin
        wr_entry.addr = FIX_BASE + {8'd0, CD_TR_WR_ADDR[17:1]};
        byte_wr       = 1'b1;
      end
      default: begin
        wr_entry.addr = 25'd0;
        byte_wr       = 1'b0;
      end
    endcase
    // Byte writes replicate the low byte; odd addresses land on the lower lane.
    if (byte_wr) begin
      wr_entry.data = {CD_TR_WR_DATA[7:0], CD_TR_WR_DATA[7:0]};
      wr_entry.be   = wr_entry.addr[0] ? 2'b01 : 2'b10;
    end else begin
      wr_entry.data = CD_TR_WR_DATA;
      wr_entry.be   = 2'b11;
    end
  end

  cd_upload_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK_68KCLK),
    .rst     (RESET),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (head_raw),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign head       = head_raw;
  assign push_acc   = push && (!fifo_full || pop);
  assign count_next = fifo_count + CW'(push_acc) - CW'(pop);

  // Drain FSM next state and output register loads.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ST_REQ;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (MEM_ACK && !fifo_empty) begin
          pop        = 1'b1;
          state_next = ST_REQ;
        end else if (MEM_ACK) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_REQ;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (pop) begin
      addr_next = head.addr;
      data_next = head.data;
      be_next   = head.be;
    end else begin
      addr_next = MEM_ADDR;
      data_next = MEM_DATA;
      be_next   = MEM_BE;
    end
    req_next  = (state_next == ST_REQ);
    busy_next = (count_next != CW'(0)) || req_next;
  end

  // State, output and sticky flag registers.
  always_ff @(posedge CLK_68KCLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      MEM_REQ   <= 1'b0;
      MEM_ADDR  <= 25'd0;
      MEM_DATA  <= 16'd0;
      MEM_BE    <= 2'b00;
      BUSY      <= 1'b0;
      OVERFLOW  <= 1'b0;
      COLLISION <= 1'b0;
    end else begin
      state     <= state_next;
      MEM_REQ   <= req_next;
      MEM_ADDR  <= addr_next;
      MEM_DATA  <= data_next;
      MEM_BE    <= be_next;
      BUSY      <= busy_next;
      OVERFLOW  <= OVERFLOW | (push && !push_acc);
      COLLISION <= COLLISION | (n_strobes > 3'd1);
    end
  end

endmodule

// File: tb/tb_cd_upload_writer.sv
// Directed bench for cd_upload_writer with a queue-based scoreboard.
module tb_cd_upload_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_spr, wr_pcm, wr_z80, wr_fix;
  logic [18:0] wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  bank_spr;
  logic        bank_pcm;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [24:0] mem_addr;
  logic [15:0] mem_data;
  logic [1:0]  mem_be;
  logic        busy, overflow, collision;

  int checks = 0;
  int failures = 0;
  logic ack_en = 1'b0;
  logic ack_force = 1'b0;
  logic saw_req = 1'b0;
  logic [42:0] sb[$];

  cd_upload_writer dut (
    .CLK_68KCLK    (clk),
    .RESET         (rst),
    .CD_TR_WR_SPR  (wr_spr),
    .CD_TR_WR_PCM  (wr_pcm),
    .CD_TR_WR_Z80  (wr_z80),
    .CD_TR_WR_FIX  (wr_fix),
    .CD_TR_WR_ADDR (wr_addr),
    .CD_TR_WR_DATA (wr_data),
    .CD_BANK_SPR   (bank_spr),
    .CD_BANK_PCM   (bank_pcm),
    .MEM_REQ       (mem_req),
    .MEM_ACK       (mem_ack),
    .MEM_ADDR      (mem_addr),
    .MEM_DATA      (mem_data),
    .MEM_BE        (mem_be),
    .BUSY          (busy),
    .OVERFLOW      (overflow),
    .COLLISION     (collision)
  );

  always #5 clk = ~clk;

  // Memory-side responder: acks in the same cycle REQ is seen, when enabled.
  always @(posedge clk) begin
    #1;
    mem_ack = ack_force || (ack_en && mem_req);
  end

  // Scoreboard monitor: every accepted handshake must match the queue head.
  always @(negedge clk) begin
    if (mem_req) saw_req = 1'b1;
    if (!rst && mem_req && mem_ack) begin
      logic [42:0] got;
      logic [42:0] exp;
      got = {mem_addr, mem_data, mem_be};
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_req got=%h required=none", got);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          failures++;
          $display("FAIL handshake got addr=%h data=%h be=%b required addr=%h data=%h be=%b",
                   got[42:18], got[17:2], got[1:0], exp[42:18], exp[17:2], exp[1:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_wr(input logic [24:0] a, input logic [15:0] d, input logic [1:0] be);
    sb.push_back({a, d, be});
  endtask

  // Drives the strobes {spr,pcm,z80,fix} for exactly one cycle.
  task automatic strobe(input logic [3:0] s, input logic [18:0] a, input logic [15:0] d);
    {wr_spr, wr_pcm, wr_z80, wr_fix} = s;
    wr_addr = a;
    wr_data = d;
    cyc(1);
    {wr_spr, wr_pcm, wr_z80, wr_fix} = 4'b0000;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || mem_req) && n < 200) begin
      cyc(1);
      n++;
    end
    chk(name, 32'(sb.size() != 0 || mem_req), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    {wr_spr, wr_pcm, wr_z80, wr_fix} = 4'b0000;
    wr_addr = 19'd0;
    wr_data = 16'd0;
    bank_spr = 2'd0;
    bank_pcm = 1'b0;
    cyc(3);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data_be", 32'({mem_data, mem_be}), 32'd0);
    chk("rst_flags", 32'({busy, overflow, collision}), 32'd0);
    rst = 1'b0;
    cyc(2);

    // Single SPR write: REQ rises two cycles after the strobe.
    ack_en = 1'b1;
    bank_spr = 2'd2;
    expect_wr(25'h0200020, 16'hBEEF, 2'b11);
    strobe(4'b1000, 19'h00010, 16'hBEEF);
    chk("spr_req_n1", 32'(mem_req), 32'd0);
    chk("spr_busy_n1", 32'(busy), 32'd1);
    cyc(1);
    chk("spr_req_n2", 32'(mem_req), 32'd1);
    chk("spr_addr_n2", 32'(mem_addr), 32'h0200020);
    cyc(1);
    chk("spr_req_drop", 32'(mem_req), 32'd0);
    chk("spr_busy_drop", 32'(busy), 32'd0);

    // Byte areas: Z80 odd, FIX even, PCM with bank at the window top.
    bank_pcm = 1'b1;
    expect_wr(25'h0500003, 16'hA5A5, 2'b01);
    strobe(4'b0010, 19'h00003, 16'h12A5);
    expect_wr(25'h0510002, 16'h3C3C, 2'b10);
    strobe(4'b0001, 19'h00002, 16'h773C);
    expect_wr(25'h04FFFFF, 16'h5A5A, 2'b01);
    strobe(4'b0100, 19'h7FFFF, 16'hFF5A);
    wait_drain("byte_drain");

    // SPR and FIX together: only SPR is queued.
    bank_spr = 2'd0;
    expect_wr(25'h000000A, 16'h1234, 2'b11);
    strobe(4'b1001, 19'h00005, 16'h1234);
    wait_drain("collide_drain");
    chk("collision", 32'(collision), 32'd1);
    chk("no_overflow_yet", 32'(overflow), 32'd0);

    // Burst with ACK withheld: 9 fit (1 in output regs + 8 queued), 10th is dropped.
    ack_en = 1'b0;
    bank_spr = 2'd1;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) expect_wr(25'h0100000 + 25'(2 * i), 16'hA000 + 16'(i), 2'b11);
      strobe(4'b1000, 19'(i), 16'hA000 + 16'(i));
    end
    cyc(1);
    chk("burst_overflow", 32'(overflow), 32'd1);
    chk("burst_req_held", 32'(mem_req), 32'd1);
    chk("burst_addr_held", 32'(mem_addr), 32'h0100000);
    ack_en = 1'b1;
    wait_drain("burst_drain");
    chk("burst_busy_idle", 32'(busy), 32'd0);

    // Reset while REQ is held with 3 entries queued.
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) strobe(4'b1000, 19'(i), 16'h0F00 + 16'(i));
    cyc(2);
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    cyc(1);
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_flags", 32'({overflow, collision}), 32'd0);
    sb.delete();
    rst = 1'b0;
    saw_req = 1'b0;
    ack_force = 1'b1;
    cyc(20);
    ack_force = 1'b0;
    chk("post_rst_no_req", 32'(saw_req), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
